// File: rtl/minesweeper_pkg.sv
// Shared types and sizing constants for the Minesweeper controller and datapath.
package minesweeper_pkg;

    localparam int unsigned N_CELLS = 25;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned TIMEOUT = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PLACE,
        S_WAIT_MOVE,
        S_LOAD,
        S_DECODE,
        S_ALU,
        S_DISPLAY,
        S_OVER,
        S_ERROR
    } ctrl_state_t;

endpackage

// File: rtl/hs_watchdog.sv
// Handshake watchdog: loadable down-counter, expires when a watched wait exhausts its budget.
module hs_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    // Reload on entry to a watched state, then count down while it is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= CW'(TIMEOUT - 1);
        end else if (clr) begin
            r_cnt <= CW'(TIMEOUT - 1);
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign expired = en && (r_cnt == '0);

endmodule

// File: rtl/game_ctrl.sv
// Minesweeper sequencing controller: accepts moves and steps the datapath through
// load/decode/alu/display with done handshakes and a watchdog.
module game_ctrl
    import minesweeper_pkg::*;
#(
    parameter int unsigned N_CELLS = minesweeper_pkg::N_CELLS,
    parameter int unsigned IDX_W   = minesweeper_pkg::IDX_W,
    parameter int unsigned TIMEOUT = minesweeper_pkg::TIMEOUT
) (
    input  logic               clka,
    input  logic               restart_n,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [IDX_W-1:0]   move_idx,
    output logic               move_ready,
    output logic               move_err,
    input  logic [N_CELLS-1:0] cleared,
    input  logic               place_done,
    input  logic               alu_done,
    input  logic               display_done,
    input  logic               gameover,
    input  logic               win,
    output logic               start,
    output logic               load,
    output logic               decode,
    output logic               alu,
    output logic               display,
    output logic [IDX_W-1:0]   data,
    output logic               game_active,
    output logic               game_over,
    output logic               game_won,
    output logic               hs_err,
    output logic [4:0]         move_cnt
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next;
    logic             w_accept;
    logic             w_reject;
    logic             w_idx_ok;
    logic             w_wd_clr;
    logic             w_wd_en;
    logic             w_expired;
    logic             w_watched_next;
    logic [IDX_W-1:0] r_data;
    logic [4:0]       r_move_cnt;
    logic             r_move_err;
    logic             r_game_active;
    logic             r_gameover_lat;
    logic             r_win_lat;

    assign w_idx_ok = (32'(move_idx) < N_CELLS) && !cleared[move_idx];

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Next state; done inputs only matter in the state that issued the command.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            S_IDLE:      if (new_game) w_next = S_PLACE;
            S_PLACE: begin
                if (place_done)     w_next = S_WAIT_MOVE;
                else if (w_expired) w_next = S_ERROR;
            end
            S_WAIT_MOVE: begin
                if (new_game) begin
                    w_next = S_PLACE;
                end else if (move_valid) begin
                    if (w_idx_ok) begin
                        w_accept = 1'b1;
                        w_next   = S_LOAD;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_LOAD:      w_next = S_DECODE;
            S_DECODE:    w_next = S_ALU;
            S_ALU: begin
                if (alu_done)       w_next = S_DISPLAY;
                else if (w_expired) w_next = S_ERROR;
            end
            S_DISPLAY: begin
                if (display_done)   w_next = r_gameover_lat ? S_OVER : S_WAIT_MOVE;
                else if (w_expired) w_next = S_ERROR;
            end
            S_OVER, S_ERROR: if (new_game) w_next = S_PLACE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Moore decode of commands and state flags.
    always_comb begin
        start      = 1'b0;
        load       = 1'b0;
        decode     = 1'b0;
        alu        = 1'b0;
        display    = 1'b0;
        move_ready = 1'b0;
        game_over  = 1'b0;
        game_won   = 1'b0;
        hs_err     = 1'b0;
        case (r_state)
            S_PLACE:     start      = 1'b1;
            S_WAIT_MOVE: move_ready = 1'b1;
            S_LOAD:      load       = 1'b1;
            S_DECODE:    decode     = 1'b1;
            S_ALU:       alu        = 1'b1;
            S_DISPLAY:   display    = 1'b1;
            S_OVER: begin
                game_over = 1'b1;
                game_won  = r_win_lat;
            end
            S_ERROR:     hs_err     = 1'b1;
            default:     ;
        endcase
    end

    assign w_watched_next = (w_next == S_PLACE) || (w_next == S_ALU) || (w_next == S_DISPLAY);
    assign w_wd_clr       = w_watched_next && (w_next != r_state);
    assign w_wd_en        = (r_state == S_PLACE) || (r_state == S_ALU) || (r_state == S_DISPLAY);

    hs_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk     (clka),
        .rst_n   (restart_n),
        .clr     (w_wd_clr),
        .en      (w_wd_en),
        .expired (w_expired)
    );

    // Per-game bookkeeping; entry to PLACE starts a fresh game.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_data         <= '0;
            r_move_cnt     <= '0;
            r_move_err     <= 1'b0;
            r_game_active  <= 1'b0;
            r_gameover_lat <= 1'b0;
            r_win_lat      <= 1'b0;
        end else begin
            r_move_err <= w_reject;
            if (w_accept) begin
                r_data        <= move_idx;
                r_game_active <= 1'b1;
                if (r_move_cnt < 5'(N_CELLS)) r_move_cnt <= r_move_cnt + 5'd1;
            end
            if ((r_state == S_ALU) && alu_done) begin
                r_gameover_lat <= gameover;
                r_win_lat      <= win;
            end
            if ((w_next == S_OVER) || (w_next == S_ERROR)) r_game_active <= 1'b0;
            if ((w_next == S_PLACE) && (r_state != S_PLACE)) begin
                r_move_cnt     <= '0;
                r_game_active  <= 1'b0;
                r_gameover_lat <= 1'b0;
                r_win_lat      <= 1'b0;
            end
        end
    end

    assign data        = r_data;
    assign move_cnt    = r_move_cnt;
    assign move_err    = r_move_err;
    assign game_active = r_game_active;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: vector table for the main flow, hand-written
// sequences for watchdog, saturation and asynchronous reset.
module tb_game_ctrl;

    logic        clka = 1'b0;
    logic        restart_n;
    logic        new_game, move_valid;
    logic [4:0]  move_idx;
    logic [24:0] cleared;
    logic        place_done, alu_done, display_done, gameover, win;
    logic        move_ready, move_err, start, load, decode, alu, display;
    logic [4:0]  data;
    logic        game_active, game_over, game_won, hs_err;
    logic [4:0]  move_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clka = ~clka;

    game_ctrl dut (
        .clka(clka), .restart_n(restart_n), .new_game(new_game),
        .move_valid(move_valid), .move_idx(move_idx), .move_ready(move_ready),
        .move_err(move_err), .cleared(cleared), .place_done(place_done),
        .alu_done(alu_done), .display_done(display_done), .gameover(gameover),
        .win(win), .start(start), .load(load), .decode(decode), .alu(alu),
        .display(display), .data(data), .game_active(game_active),
        .game_over(game_over), .game_won(game_won), .hs_err(hs_err),
        .move_cnt(move_cnt)
    );

    typedef struct packed {
        logic        ng, mv;
        logic [4:0]  idx;
        logic [24:0] clr;
        logic        pd, ad, dd, go, wn;
    } in_t;

    typedef struct packed {
        logic [4:0] cmd;   // {start, load, decode, alu, display}
        logic [4:0] data;
        logic       ready, err, active, over, won, hserr;
        logic [4:0] cnt;
    } outs_t;

    typedef struct packed {
        in_t   i;
        outs_t o;
    } vec_t;

    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_START = 5'b10000;
    localparam logic [4:0] C_LOAD  = 5'b01000;
    localparam logic [4:0] C_DEC   = 5'b00100;
    localparam logic [4:0] C_ALU   = 5'b00010;
    localparam logic [4:0] C_DISP  = 5'b00001;

    function automatic in_t mk_in(logic ng, logic mv, logic [4:0] idx, logic [24:0] clr,
                                  logic pd, logic ad, logic dd, logic go, logic wn);
        return '{ng: ng, mv: mv, idx: idx, clr: clr, pd: pd, ad: ad, dd: dd, go: go, wn: wn};
    endfunction

    function automatic outs_t mk_out(logic [4:0] cmd, logic [4:0] d, logic rdy, logic err,
                                     logic act, logic ovr, logic won, logic hse, logic [4:0] cnt);
        return '{cmd: cmd, data: d, ready: rdy, err: err, active: act, over: ovr,
                 won: won, hserr: hse, cnt: cnt};
    endfunction

    function automatic outs_t cur();
        return mk_out({start, load, decode, alu, display}, data, move_ready, move_err,
                      game_active, game_over, game_won, hs_err, move_cnt);
    endfunction

    task automatic drive(input in_t v);
        new_game     = v.ng;
        move_valid   = v.mv;
        move_idx     = v.idx;
        cleared      = v.clr;
        place_done   = v.pd;
        alu_done     = v.ad;
        display_done = v.dd;
        gameover     = v.go;
        win          = v.wn;
    endtask

    task automatic step(input in_t v);
        drive(v);
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string name, input outs_t exp);
        outs_t act;
        act = cur();
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    vec_t tv[$];
    in_t  idle;
    int   n_alu;
    int   exp_cnt;

    initial begin
        idle = mk_in(0, 0, 5'd0, 25'd0, 0, 0, 0, 0, 0);
        tv.push_back('{mk_in(1,0,0,0,0,0,0,0,0),                mk_out(C_START,0,0,0,0,0,0,0,0)});
        tv.push_back('{idle,                                     mk_out(C_START,0,0,0,0,0,0,0,0)});
        tv.push_back('{idle,                                     mk_out(C_START,0,0,0,0,0,0,0,0)});
        tv.push_back('{idle,                                     mk_out(C_START,0,0,0,0,0,0,0,0)});
        tv.push_back('{mk_in(0,0,0,0,1,0,0,0,0),                mk_out(C_NONE,0,1,0,0,0,0,0,0)});
        tv.push_back('{mk_in(0,1,12,0,0,0,0,0,0),               mk_out(C_LOAD,12,0,0,1,0,0,0,1)});
        tv.push_back('{idle,                                     mk_out(C_DEC,12,0,0,1,0,0,0,1)});
        tv.push_back('{idle,                                     mk_out(C_ALU,12,0,0,1,0,0,0,1)});
        tv.push_back('{mk_in(0,0,0,0,0,1,0,0,0),                mk_out(C_DISP,12,0,0,1,0,0,0,1)});
        tv.push_back('{mk_in(0,0,0,0,0,0,1,0,0),                mk_out(C_NONE,12,1,0,1,0,0,0,1)});
        tv.push_back('{mk_in(0,1,25,0,0,0,0,0,0),               mk_out(C_NONE,12,1,1,1,0,0,0,1)});
        tv.push_back('{idle,                                     mk_out(C_NONE,12,1,0,1,0,0,0,1)});
        tv.push_back('{mk_in(0,1,3,25'h8,0,0,0,0,0),            mk_out(C_NONE,12,1,1,1,0,0,0,1)});
        tv.push_back('{idle,                                     mk_out(C_NONE,12,1,0,1,0,0,0,1)});
        tv.push_back('{mk_in(0,1,24,25'h1000,0,0,0,0,0),        mk_out(C_LOAD,24,0,0,1,0,0,0,2)});
        tv.push_back('{idle,                                     mk_out(C_DEC,24,0,0,1,0,0,0,2)});
        tv.push_back('{mk_in(1,0,0,0,0,0,0,0,0),                mk_out(C_ALU,24,0,0,1,0,0,0,2)});
        tv.push_back('{mk_in(1,0,0,0,0,0,0,0,0),                mk_out(C_ALU,24,0,0,1,0,0,0,2)});
        tv.push_back('{mk_in(0,0,0,0,0,1,0,1,0),                mk_out(C_DISP,24,0,0,1,0,0,0,2)});
        tv.push_back('{idle,                                     mk_out(C_DISP,24,0,0,1,0,0,0,2)});
        tv.push_back('{mk_in(0,0,0,0,0,0,1,0,0),                mk_out(C_NONE,24,0,0,0,1,0,0,2)});
        tv.push_back('{mk_in(0,0,0,0,0,1,1,0,0),                mk_out(C_NONE,24,0,0,0,1,0,0,2)});
        tv.push_back('{mk_in(1,0,0,0,0,0,0,0,0),                mk_out(C_START,24,0,0,0,0,0,0,0)});
        tv.push_back('{mk_in(0,0,0,0,1,0,0,0,0),                mk_out(C_NONE,24,1,0,0,0,0,0,0)});
        tv.push_back('{mk_in(0,1,0,0,0,0,0,0,0),                mk_out(C_LOAD,0,0,0,1,0,0,0,1)});
        tv.push_back('{idle,                                     mk_out(C_DEC,0,0,0,1,0,0,0,1)});
        tv.push_back('{idle,                                     mk_out(C_ALU,0,0,0,1,0,0,0,1)});
        tv.push_back('{mk_in(0,0,0,0,0,1,0,1,1),                mk_out(C_DISP,0,0,0,1,0,0,0,1)});
        tv.push_back('{mk_in(0,0,0,0,0,0,1,0,0),                mk_out(C_NONE,0,0,0,0,1,1,0,1)});
        tv.push_back('{mk_in(1,0,0,0,0,0,0,0,0),                mk_out(C_START,0,0,0,0,0,0,0,0)});
        tv.push_back('{mk_in(0,0,0,0,1,0,0,0,0),                mk_out(C_NONE,0,1,0,0,0,0,0,0)});
        tv.push_back('{mk_in(1,1,5,0,0,0,0,0,0),                mk_out(C_START,0,0,0,0,0,0,0,0)});
        tv.push_back('{mk_in(0,0,0,0,1,0,0,0,0),                mk_out(C_NONE,0,1,0,0,0,0,0,0)});
        tv.push_back('{mk_in(0,0,0,0,0,1,1,0,0),                mk_out(C_NONE,0,1,0,0,0,0,0,0)});

        restart_n = 1'b0;
        drive(idle);
        repeat (2) @(posedge clka);
        #1;
        chk("reset", mk_out(C_NONE,0,0,0,0,0,0,0,0));
        restart_n = 1'b1;
        step(idle);
        chk("idle", mk_out(C_NONE,0,0,0,0,0,0,0,0));

        foreach (tv[k]) begin
            step(tv[k].i);
            chk($sformatf("vec%0d", k), tv[k].o);
        end

        // Watchdog: ALU held without done for the full budget.
        step(mk_in(0,1,7,0,0,0,0,0,0));
        chk("wd_load", mk_out(C_LOAD,7,0,0,1,0,0,0,1));
        step(idle);
        step(idle);
        chk("wd_alu", mk_out(C_ALU,7,0,0,1,0,0,0,1));
        n_alu = 1;
        while (alu && n_alu < 40) begin
            step(idle);
            if (alu) n_alu++;
        end
        chk_int("wd_alu_cycles", n_alu, 16);
        chk("wd_error", mk_out(C_NONE,7,0,0,0,0,0,1,1));
        step(mk_in(1,0,0,0,0,0,0,0,0));
        chk("wd_restart", mk_out(C_START,7,0,0,0,0,0,0,0));
        step(mk_in(0,0,0,0,1,0,0,0,0));
        chk("wd_place_done", mk_out(C_NONE,7,1,0,0,0,0,0,0));

        // Back-to-back minimum-latency moves until move_cnt saturates.
        for (int m = 0; m < 27; m++) begin
            step(mk_in(0,1,5'(m % 25),0,0,0,0,0,0));
            step(idle);
            step(idle);
            step(mk_in(0,0,0,0,0,1,0,0,0));
            step(mk_in(0,0,0,0,0,0,1,0,0));
            exp_cnt = (m + 1 > 25) ? 25 : m + 1;
            chk($sformatf("sat%0d", m), mk_out(C_NONE,5'(m % 25),1,0,1,0,0,0,5'(exp_cnt)));
        end

        // Asynchronous reset while DISPLAY is pending.
        step(mk_in(0,1,9,0,0,0,0,0,0));
        step(idle);
        step(idle);
        step(mk_in(0,0,0,0,0,1,0,0,0));
        chk("pre_reset_disp", mk_out(C_DISP,9,0,0,1,0,0,0,25));
        #2;
        restart_n = 1'b0;
        #1;
        chk("async_reset", mk_out(C_NONE,0,0,0,0,0,0,0,0));
        @(posedge clka);
        #1;
        restart_n = 1'b1;
        step(idle);
        chk("post_reset", mk_out(C_NONE,0,0,0,0,0,0,0,0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Sequencing controller for the Minesweeper datapath. It accepts a new-game request and user cell selections. It drives the datapath command strobes (`start`, `load`, `decode`, `alu`, `display`) and the 5-bit `data` index, and waits on the datapath done/status handshakes. The block is the initiator side of the datapath command interface and sits between the user-input front end and `dp`.

## Interface
Parameters:
- `N_CELLS`, 25: number of board cells; a valid index is 0..N_CELLS-1.
- `IDX_W`, 5: cell index width.
- `TIMEOUT`, 16: maximum cycles to wait for a done handshake before declaring an error.

Ports:
- `clka` input 1: single system clock. All logic runs on the rising edge.
- `restart_n` input 1: reset, asynchronous, active-low.
- `new_game` input 1: single-cycle request to (re)start a game.
- `move_valid` input 1: user move offered.
- `move_idx` input IDX_W: cell index of the offered move.
- `move_ready` output 1: controller can accept a move.
- `move_err` output 1: one-cycle pulse when an offered move is rejected.
- `cleared` input N_CELLS: cleared-cell mask from the datapath.
- `place_done`, `alu_done`, `display_done` input 1 each: datapath done handshakes.
- `gameover`, `win` input 1 each: datapath status, valid while `alu_done` is high.
- `start`, `load`, `decode`, `alu`, `display` output 1 each: datapath commands. At most one is high at any time.
- `data` output IDX_W: latched move index.
- `game_active` output 1: high from accepting the first move until the game ends.
- `game_over` output 1: high in OVER.
- `game_won` output 1: high in OVER when the last move won.
- `hs_err` output 1: high in ERROR.
- `move_cnt` output 5: accepted moves this game, saturating at N_CELLS.

## Operation
- **Reset.** State is IDLE. Every output is 0: commands, `data`, `move_ready`, `move_err`, flags and `move_cnt`.
- **States.** IDLE, PLACE, WAIT_MOVE, LOAD, DECODE, ALU, DISPLAY, OVER, ERROR.
- **Command outputs.** They are Moore outputs decoded from the registered state:
  - PLACE drives `start`.
  - LOAD drives `load`.
  - DECODE drives `decode`.
  - ALU drives `alu`.
  - DISPLAY drives `display`.
- **Transitions:**
  - IDLE: `new_game` goes to PLACE.
  - PLACE: `place_done` goes to WAIT_MOVE. Entry to PLACE clears `move_cnt`, `game_won` and `hs_err`.
  - WAIT_MOVE: `move_ready`=1. If `move_valid` is high, the move is accepted only when `move_idx` < N_CELLS and `cleared[move_idx]`=0. On acceptance, `data` latches `move_idx`, `move_cnt` increments (saturating), `game_active` is set, and the next state is LOAD. Otherwise `move_err` pulses for one cycle and the state is unchanged.
  - LOAD: exactly one cycle, then DECODE.
  - DECODE: exactly one cycle, then ALU.
  - ALU: hold `alu` until `alu_done`. In that cycle, latch `gameover` and `win` internally, then go to DISPLAY.
  - DISPLAY: hold `display` until `display_done`. Then go to OVER if the latched gameover is set, else WAIT_MOVE.
  - OVER: `game_over`=1, `game_won` equals the latched win, `game_active`=0. `new_game` goes to PLACE.
  - ERROR: `hs_err`=1 and all commands are 0. `new_game` goes to PLACE.
- **Watchdog.** It counts cycles spent in PLACE, ALU or DISPLAY and clears on entry to each. If the count reaches TIMEOUT-1 with no done, the next state is ERROR.
- **Done filtering.** A done input asserted while its command is inactive is ignored.
- **Simultaneous events.**
  - In WAIT_MOVE, `new_game` and `move_valid` together: `new_game` wins, the next state is PLACE, and there is no `move_err`.
  - `new_game` during LOAD, DECODE, ALU or DISPLAY is ignored, so a transaction is never aborted mid-way.
- **Reset mid-operation.** All state and outputs return to reset values immediately (asynchronously), regardless of datapath state.
- **`move_cnt` saturation.** It holds at 25 and never wraps.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Accept at cycle T gives `load`=1 at T+1, `decode`=1 at T+2 and `alu`=1 at T+3.
- Done sampled high at cycle k gives the next state's command at k+1. The command is deasserted at k+1.
- The minimum move turnaround, done signals permitting, is 5 cycles from accept to a return to WAIT_MOVE with `move_ready` high.
- `move_err` is high in the cycle after the rejected offer, for one cycle.
- Timeout: the command has been high for TIMEOUT cycles with no done, and ERROR is entered in the next cycle.

## Structure
- Shared package `minesweeper_pkg` holds:
  - the state enum `ctrl_state_t`;
  - the constants `N_CELLS`, `IDX_W` and `TIMEOUT`.
- Sub-module `hs_watchdog` is a loadable down-counter with inputs `clr` and `en` and a single-cycle `expired` output. The controller instantiates one.
- All else stays flat in `game_ctrl`.

## Test plan
- **Reset and start.** Release reset, then pulse `new_game`; `start` rises the next cycle. Assert `place_done` 3 cycles later; `move_ready`=1 the cycle after.
- **Normal move.** Offer `move_idx`=12 with `cleared`=0; `data`=12 and `load`, `decode`, `alu` follow on consecutive cycles. Return `alu_done` with `gameover`=0, then `display_done`; back to WAIT_MOVE with `move_cnt`=1.
- **Rejections.** Offer `move_idx`=25 and `move_idx`=3 with `cleared[3]`=1; each gives a one-cycle `move_err`, no `load`, and `move_cnt` unchanged.
- **Mine hit and win.**
  - `alu_done` with `gameover`=1, `win`=0: after `display_done`, `game_over`=1 and `game_won`=0.
  - Repeat with `win`=1: `game_won`=1.
  - Then `new_game`: PLACE entered and `move_cnt`=0.
- **Watchdog.** Hold `alu_done`=0 for 16 cycles; `hs_err`=1 and `alu`=0. `new_game` clears `hs_err`.
- **Priority and abort.**
  - `new_game` with `move_valid` in WAIT_MOVE goes to PLACE.
  - `new_game` during ALU is ignored.
  - `restart_n` low during DISPLAY zeroes all outputs immediately.
